puf_challenge_sequencer: RTL and testbench

Sequential, parametrised successor to the arbiter-PUF challenge input network. It accepts a seed over a valid/ready handshake and expands it with an internal N_CB-bit LFSR into a burst of N_CHAL challenges. Each challenge is optionally passed through the PUF input-network XOR transform and presented to the arbiter chain over a second valid/ready handshake. It sits between the BIST controller (seed source) and the PUF delay-chain challenge inputs.

---
 rtl/puf_challenge_sequencer.sv | 121 ++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_sequencer.sv
// Seeded LFSR challenge generator for the arbiter-PUF chain, with optional input-network transform.
// Optional chal_par output (registered parity of chal) is enabled by defining CHAL_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for a seed, seed_ready = 1
// RUN   | burst in progress, presenting challenges, busy = 1
module puf_challenge_sequencer #(
  parameter int                N_CB   = 32,
  parameter int                N_CHAL = 16,
  parameter logic [N_CB-1:0]   TAPS   = N_CB'(32'h8020_0003),
  localparam int               CNT_W  = (N_CHAL > 1) ? $clog2(N_CHAL) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic [N_CB-1:0]   seed,
  input  logic              mode,
  input  logic              abort,
  output logic              chal_valid,
  input  logic              chal_ready,
  output logic [N_CB-1:0]   chal,
  output logic [CNT_W-1:0]  chal_idx,
  output logic              chal_last,
`ifdef CHAL_PARITY_EN
  output logic              chal_par,
`endif
  output logic              busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CHAL - 1);

  state_t           state;
  logic [N_CB-1:0]  lfsr;
  logic             mode_q;
  logic [CNT_W-1:0] idx;

  logic [N_CB-1:0]  seed_nz;
  logic [N_CB-1:0]  lfsr_step;
  logic [N_CB-1:0]  load_src;
  logic             load_mode;
  logic [N_CB-1:0]  chal_nxt;

  // Pairwise XOR fold: low half from adjacent pairs (0,1),(2,3)..., upper half from d[0] and shifted pairs.
  function automatic logic [N_CB-1:0] input_net(input logic [N_CB-1:0] d);
    logic [N_CB-1:0] c;
    c = '0;
    c[N_CB/2] = d[0];
    for (int k = 1; k < N_CB; k += 2)
      c[(k-1)/2] = d[k-1] ^ d[k];
    for (int m = 2; m <= N_CB-2; m += 2)
      c[N_CB/2 + m/2] = d[m-1] ^ d[m];
    return c;
  endfunction

  always_comb begin
    seed_nz   = (seed == '0) ? N_CB'(1) : seed;
    lfsr_step = {lfsr[N_CB-2:0], ^(lfsr & TAPS)};
    load_src  = (state == IDLE) ? seed_nz : lfsr_step;
    load_mode = (state == IDLE) ? mode : mode_q;
    chal_nxt  = load_mode ? input_net(load_src) : load_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= '0;
      mode_q     <= 1'b0;
      idx        <= '0;
      chal       <= '0;
      chal_valid <= 1'b0;
`ifdef CHAL_PARITY_EN
      chal_par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (seed_valid && !abort) begin
            lfsr       <= seed_nz;
            mode_q     <= mode;
            idx        <= '0;
            chal       <= chal_nxt;
            chal_valid <= 1'b1;
            state      <= RUN;
`ifdef CHAL_PARITY_EN
            chal_par   <= ^chal_nxt;
`endif
          end
        end
        RUN: begin
          // abort wins over a same-cycle handshake, so that challenge is dropped uncounted
          if (abort) begin
            chal_valid <= 1'b0;
            state      <= IDLE;
          end else if (chal_valid && chal_ready) begin
            if (idx == LAST) begin
              chal_valid <= 1'b0;
              state      <= IDLE;
            end else begin
              lfsr <= lfsr_step;
              idx  <= idx + CNT_W'(1);
              chal <= chal_nxt;
`ifdef CHAL_PARITY_EN
              chal_par <= ^chal_nxt;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign seed_ready = (state == IDLE);
  assign busy       = (state == RUN);
  assign chal_idx   = idx;
  assign chal_last  = chal_valid && (idx == LAST);

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Randomized self-checking bench for puf_challenge_sequencer (N_CB=8, N_CHAL=5, TAPS=8'hB8).
// Define CHAL_PARITY_EN on both compiles to also check chal_par.
module tb_puf_challenge_sequencer;

  localparam int N_CB   = 8;
  localparam int N_CHAL = 5;
  localparam logic [7:0] TAPS = 8'hB8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seed_valid = 1'b0;
  logic       seed_ready;
  logic [7:0] seed = '0;
  logic       mode = 1'b0;
  logic       abort = 1'b0;
  logic       chal_valid;
  logic       chal_ready = 1'b0;
  logic [7:0] chal;
  logic [2:0] chal_idx;
  logic       chal_last;
  logic       busy;
`ifdef CHAL_PARITY_EN
  logic       chal_par;
`endif

  int tests = 0;
  int fails = 0;

  puf_challenge_sequencer #(.N_CB(N_CB), .N_CHAL(N_CHAL), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n),
    .seed_valid(seed_valid), .seed_ready(seed_ready), .seed(seed), .mode(mode),
    .abort(abort),
    .chal_valid(chal_valid), .chal_ready(chal_ready), .chal(chal),
    .chal_idx(chal_idx), .chal_last(chal_last),
`ifdef CHAL_PARITY_EN
    .chal_par(chal_par),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: LFSR as shift-left with feedback = parity of tapped bits.
  function automatic logic [7:0] model_step(input logic [7:0] cur);
    return 8'((cur << 1) | 8'($countones(cur & TAPS) % 2));
  endfunction

  // Reference transform per output bit: low half pairs (2i,2i+1), bit 4 = d0, upper bits pairs (2j-1,2j).
  function automatic logic [7:0] model_xf(input logic [7:0] d);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) begin
      if (i < 4)       c[i] = d[2*i] ^ d[2*i+1];
      else if (i == 4) c[i] = d[0];
      else             c[i] = d[2*(i-4)-1] ^ d[2*(i-4)];
    end
    return c;
  endfunction

  task automatic start_seed(input logic [7:0] s, input logic m);
    int n = 0;
    while (!seed_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (!seed_ready) begin
      fails++;
      $display("FAIL seed_ready_timeout: got %0b expected 1", seed_ready);
    end
    seed = s; mode = m; seed_valid = 1'b1;
    @(posedge clk); #1;
    seed_valid = 1'b0; seed = 8'($urandom); mode = 1'($urandom);
  endtask

  // rmode: 0 = ready always, 1 = stall 3 cycles at idx 2, 2 = random ready.
  task automatic do_burst(input logic [7:0] s, input logic m, input int rmode);
    logic [7:0] exp_c [N_CHAL];
    logic [7:0] cur;
    int idx = 0, cyc = 0, stall = 0;
    cur = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < N_CHAL; i++) begin
      exp_c[i] = m ? model_xf(cur) : cur;
      cur = model_step(cur);
    end
    start_seed(s, m);
    while (idx < N_CHAL && cyc < 100) begin
      tests++;
      if (chal_valid !== 1'b1) begin fails++; $display("FAIL burst_valid idx%0d: got %b expected 1", idx, chal_valid); end
      tests++;
      if (chal !== exp_c[idx]) begin fails++; $display("FAIL burst_chal idx%0d: got %h expected %h", idx, chal, exp_c[idx]); end
      tests++;
      if (chal_idx !== 3'(idx)) begin fails++; $display("FAIL burst_idx: got %0d expected %0d", chal_idx, idx); end
      tests++;
      if (chal_last !== (idx == N_CHAL-1)) begin fails++; $display("FAIL burst_last idx%0d: got %b expected %b", idx, chal_last, idx == N_CHAL-1); end
      tests++;
      if (busy !== 1'b1 || seed_ready !== 1'b0) begin fails++; $display("FAIL burst_busy idx%0d: got busy=%b seed_ready=%b expected 1/0", idx, busy, seed_ready); end
`ifdef CHAL_PARITY_EN
      tests++;
      if (chal_par !== ^exp_c[idx]) begin fails++; $display("FAIL burst_par idx%0d: got %b expected %b", idx, chal_par, ^exp_c[idx]); end
`endif
      case (rmode)
        0: chal_ready = 1'b1;
        1: begin
          if (idx == 2 && stall < 3) begin chal_ready = 1'b0; stall++; end
          else chal_ready = 1'b1;
        end
        default: chal_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      if (chal_ready) idx++;
      cyc++;
    end
    chal_ready = 1'b0;
    tests++;
    if (idx < N_CHAL) begin fails++; $display("FAIL burst_timeout: got %0d challenges expected %0d", idx, N_CHAL); end
    tests++;
    if (chal_valid !== 1'b0 || seed_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL burst_end: got valid=%b seed_ready=%b busy=%b expected 0/1/0", chal_valid, seed_ready, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    tests++;
    if (chal_valid !== 1'b0 || chal !== 8'h00 || chal_idx !== 3'd0 || chal_last !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b chal=%h idx=%0d last=%b busy=%b expected all 0", chal_valid, chal, chal_idx, chal_last, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (seed_ready !== 1'b1) begin fails++; $display("FAIL reset_seed_ready: got %b expected 1", seed_ready); end
  endtask

  task automatic test_first_values;
    logic [7:0] s_t [4] = '{8'h01, 8'h01, 8'hFF, 8'h00};
    logic       m_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] e_t [4] = '{8'h01, 8'h11, 8'h10, 8'h01};
    for (int i = 0; i < 4; i++) begin
      start_seed(s_t[i], m_t[i]);
      tests++;
      if (chal !== e_t[i] || chal_valid !== 1'b1) begin
        fails++;
        $display("FAIL first_chal seed=%h mode=%b: got %h valid=%b expected %h valid=1", s_t[i], m_t[i], chal, chal_valid, e_t[i]);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
  endtask

  task automatic test_sequence;
    do_burst(8'h01, 1'b0, 0);
    do_burst(8'h01, 1'b1, 0);
    do_burst(8'h00, 1'b0, 0);
  endtask

  task automatic test_backpressure;
    do_burst(8'h01, 1'b0, 1);
    do_burst(8'h5A, 1'b1, 1);
  endtask

  task automatic test_abort;
    start_seed(8'h01, 1'b0);
    chal_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (chal_idx !== 3'd1 || chal !== 8'h02) begin fails++; $display("FAIL abort_pre: got idx=%0d chal=%h expected 1/02", chal_idx, chal); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; chal_ready = 1'b0;
    tests++;
    if (chal_valid !== 1'b0 || seed_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_run: got valid=%b seed_ready=%b busy=%b expected 0/1/0", chal_valid, seed_ready, busy);
    end
    abort = 1'b1; seed_valid = 1'b1; seed = 8'h33;
    @(posedge clk); #1;
    abort = 1'b0; seed_valid = 1'b0;
    tests++;
    if (busy !== 1'b0 || chal_valid !== 1'b0) begin fails++; $display("FAIL abort_idle_block: got busy=%b valid=%b expected 0/0", busy, chal_valid); end
    do_burst(8'h02, 1'b0, 0);
  endtask

  task automatic test_reset_mid;
    start_seed(8'h01, 1'b0);
    chal_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chal_ready = 1'b0;
    tests++;
    if (chal_idx !== 3'd3 || chal !== 8'h08) begin fails++; $display("FAIL rstmid_pre: got idx=%0d chal=%h expected 3/08", chal_idx, chal); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (chal_valid !== 1'b0 || chal !== 8'h00 || chal_idx !== 3'd0 || chal_last !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async: got valid=%b chal=%h idx=%0d last=%b busy=%b expected all 0", chal_valid, chal, chal_idx, chal_last, busy);
    end
`ifdef CHAL_PARITY_EN
    tests++;
    if (chal_par !== 1'b0) begin fails++; $display("FAIL rstmid_par: got %b expected 0", chal_par); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (seed_ready !== 1'b1) begin fails++; $display("FAIL rstmid_seed_ready: got %b expected 1", seed_ready); end
    do_burst(8'h01, 1'b0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++)
      do_burst(8'($urandom), 1'($urandom), 2);
  endtask

  initial begin
    test_reset();
    test_first_values();
    test_sequence();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
